// File: rtl/ntr_pkg.sv
// ntr_pkg: opcodes, state and source types shared by the NTR transfer controller
package ntr_pkg;
    localparam logic [7:0] OP_READ_DATA = 8'hB7;
    localparam logic [7:0] OP_CHIP_ID   = 8'h90;
    localparam logic [7:0] OP_CHIP_ID2  = 8'hB8;
    localparam logic [7:0] OP_DUMMY     = 8'h9F;
    typedef enum logic [2:0] {IDLE, DECODE, LOAD, STREAM, DONE} state_t;
    typedef enum logic [1:0] {MEM, ID, FILL} src_t;
    function automatic logic op_known(input logic [7:0] op);
        return op inside {OP_READ_DATA, OP_CHIP_ID, OP_CHIP_ID2, OP_DUMMY};
    endfunction
endpackage

// File: rtl/ntr_xfer_ctrl_if.sv
// ntr_xfer_ctrl_if: command, memory and serializer signals of the NTR transfer controller
interface ntr_xfer_ctrl_if;
    logic        cmd_valid;
    logic [63:0] cmd;
    logic        abort;
    logic        word_req;
    logic [31:0] word_addr;
    logic        word_ack;
    logic [31:0] word_in;
    logic [31:0] ser_word;
    logic        ser_en;
    logic        ser_req;
    logic        busy;
    logic        done;
    logic        err;
    modport slave (
        input  cmd_valid, cmd, abort, word_ack, word_in, ser_req,
        output word_req, word_addr, ser_word, ser_en, busy, done, err
    );
    modport master (
        output cmd_valid, cmd, abort, word_ack, word_in, ser_req,
        input  word_req, word_addr, ser_word, ser_en, busy, done, err
    );
endinterface

// File: rtl/ntr_word_fetch.sv
// ntr_word_fetch: memory req/ack engine with a one-word buffer and auto-incrementing address
module ntr_word_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_addr,
    input  logic        i_fetch,
    input  logic        i_take,
    input  logic        i_flush,
    input  logic        i_ack,
    input  logic [31:0] i_data,
    output logic        o_req,
    output logic [31:0] o_addr,
    output logic        o_avail,
    output logic [31:0] o_data
);
    logic        r_req;
    logic        r_buf_v;
    logic [31:0] r_buf;
    logic [31:0] r_addr;
    logic        w_hit;
    assign w_hit   = r_req && i_ack;
    assign o_req   = r_req;
    assign o_addr  = r_addr;
    // an ack in the same cycle as a take is forwarded straight through
    assign o_avail = r_buf_v || w_hit;
    assign o_data  = r_buf_v ? r_buf : i_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req   <= 1'b0;
            r_buf_v <= 1'b0;
            r_buf   <= '0;
            r_addr  <= '0;
        end else begin
            r_req   <= !i_flush && (i_fetch || (r_req && !i_ack));
            r_buf_v <= !i_flush && !i_take && (r_buf_v || w_hit);
            r_buf   <= w_hit ? i_data : r_buf;
            r_addr  <= i_load ? i_addr : (w_hit && !i_flush) ? r_addr + 32'd4 : r_addr;
        end
    end
endmodule

// File: rtl/ntr_xfer_ctrl.sv
// ntr_xfer_ctrl: card-side NTR command decode, word source select and serializer sequencing
// Define NTR_XFER_PREFETCH_EN to prefetch the next memory word while the current one streams.
module ntr_xfer_ctrl
    import ntr_pkg::*;
#(
    parameter logic [31:0] CHIP_ID     = 32'hC2FF_01C0,
    parameter int          BLOCK_WORDS = 128,
    parameter int          DUMMY_WORDS = 2048
) (
    input logic             clk,
    input logic             rst_n,
    ntr_xfer_ctrl_if.slave  bus
);
    state_t      r_state;
    src_t        r_src;
    logic [39:0] r_cmd;
    logic [15:0] r_left;
    logic [31:0] r_ser_word;
    logic        r_ser_en;
    logic        r_done;
    logic        r_err;
    logic [7:0]  w_op;
    logic        w_mem;
    logic        w_last;
    logic        w_avail;
    logic        w_fetch;
    logic        w_take;
    logic [31:0] w_data;
    logic        w_unused;
    assign w_op     = r_cmd[39:32];
    assign w_mem    = r_src == MEM;
    assign w_last   = r_left == 16'd1;
    assign w_unused = ^{bus.cmd[23:0], r_cmd[1:0]};
`ifdef NTR_XFER_PREFETCH_EN
    assign w_fetch = (r_state == DECODE && w_op == OP_READ_DATA) ||
                     (w_mem && w_avail && ((r_state == LOAD && !w_last) ||
                                           (r_state == STREAM && bus.ser_req && r_left > 16'd2)));
    assign w_take  = w_mem && w_avail && (r_state == LOAD || (r_state == STREAM && bus.ser_req && !w_last));
`else
    assign w_fetch = (r_state == DECODE && w_op == OP_READ_DATA) ||
                     (w_mem && r_state == STREAM && bus.ser_req && !w_last);
    assign w_take  = w_mem && w_avail && r_state == LOAD;
`endif
    ntr_word_fetch u_fetch (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (r_state == DECODE),
        .i_addr  ({r_cmd[31:2], 2'b00}),
        .i_fetch (w_fetch),
        .i_take  (w_take),
        .i_flush (bus.abort),
        .i_ack   (bus.word_ack),
        .i_data  (bus.word_in),
        .o_req   (bus.word_req),
        .o_addr  (bus.word_addr),
        .o_avail (w_avail),
        .o_data  (w_data)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_src      <= MEM;
            r_cmd      <= '0;
            r_left     <= '0;
            r_ser_word <= '0;
            r_ser_en   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else if (bus.abort) begin
            r_state  <= IDLE;
            r_ser_en <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: if (bus.cmd_valid) begin
                    r_cmd   <= bus.cmd[63:24];
                    r_err   <= !op_known(bus.cmd[63:56]);
                    r_state <= DECODE;
                end
                DECODE: begin
                    r_state <= op_known(w_op) ? LOAD : IDLE;
                    r_src   <= w_op == OP_READ_DATA ? MEM : w_op == OP_DUMMY ? FILL : ID;
                    r_left  <= w_op == OP_READ_DATA ? 16'(BLOCK_WORDS) :
                               w_op == OP_DUMMY ? 16'(DUMMY_WORDS) : 16'd1;
                end
                LOAD: if (!w_mem || w_avail) begin
                    r_ser_word <= w_mem ? w_data : r_src == ID ? CHIP_ID : 32'hFFFF_FFFF;
                    r_ser_en   <= 1'b1;
                    r_state    <= STREAM;
                end
                STREAM: if (bus.ser_req) begin
                    if (w_last) begin
                        r_ser_en <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_left <= r_left - 16'd1;
`ifdef NTR_XFER_PREFETCH_EN
                        if (w_mem && !w_avail) begin
                            r_err    <= 1'b1;
                            r_ser_en <= 1'b0;
                            r_state  <= LOAD;
                        end else if (w_mem) begin
                            r_ser_word <= w_data;
                        end
`else
                        r_ser_en <= 1'b0;
                        r_state  <= LOAD;
`endif
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.ser_word = r_ser_word;
    assign bus.ser_en   = r_ser_en;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.busy     = r_state != IDLE;
endmodule

// File: tb/tb_ntr_xfer_ctrl.sv
// tb_ntr_xfer_ctrl: directed bench with serializer and memory models for ntr_xfer_ctrl
module tb_ntr_xfer_ctrl;
`ifdef NTR_XFER_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    ntr_xfer_ctrl_if bus();
    ntr_xfer_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int checks = 0;
    int failures = 0;
    logic [1:0] scnt = 2'd0;
    int mcnt = 0;
    int mdelay = 2;
    logic mem_en = 1'b1;
    logic ack_force = 1'b0;
    int mode = 0;
    logic [31:0] base = '0;
    int n_acks = 0, n_words = 0, n_starts = 0, n_en = 0, n_err = 0, n_done = 0, n_req = 0;
    int s_acks, s_words, s_starts, s_en, s_err, s_done, s_req;
    logic prev_en = 1'b0;
    int lat;
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction
    function automatic logic [31:0] exp_word(input int m, input logic [31:0] b, input int k);
        return m == 0 ? 32'hC2FF_01C0 : m == 1 ? 32'hFFFF_FFFF : mem_data(b + 32'(4 * k));
    endfunction
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    assign bus.ser_req  = bus.ser_en && scnt == 2'd3;
    assign bus.word_ack = (mem_en && bus.word_req && mcnt == mdelay) || ack_force;
    assign bus.word_in  = mem_data(bus.word_addr);
    always @(posedge clk) begin
        scnt <= bus.ser_en ? scnt + 2'd1 : 2'd0;
        mcnt <= (bus.word_req && !bus.word_ack) ? mcnt + 1 : 0;
    end
    always @(negedge clk) begin
        if (bus.word_req && bus.word_ack) begin
            chk("ack_addr", bus.word_addr, base + 32'(4 * (n_acks - s_acks)));
            n_acks++;
        end
        if (bus.ser_en && scnt == 2'd0) begin
            chk("ser_word", bus.ser_word, exp_word(mode, base, n_words - s_words));
            n_words++;
            if (!prev_en) n_starts++;
        end
        n_en   += int'(bus.ser_en);
        n_err  += int'(bus.err);
        n_done += int'(bus.done);
        n_req  += int'(bus.word_req);
        prev_en = bus.ser_en;
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic snap;
        s_acks = n_acks; s_words = n_words; s_starts = n_starts; s_en = n_en;
        s_err = n_err; s_done = n_done; s_req = n_req;
    endtask
    task automatic run_cmd(input logic [63:0] c, input int m, input logic [31:0] b, input int budget, output int l);
        int n;
        mode = m;
        base = b;
        snap();
        bus.cmd = c;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        l = 1;
        while (!bus.ser_en && bus.busy && l < budget) begin
            tick();
            l++;
        end
        n = 0;
        while (bus.busy && n < budget) begin
            tick();
            n++;
        end
        chk("timeout", 32'(n < budget), 32'd1);
    endtask
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd = '0;
        bus.abort = 1'b0;
        repeat (3) tick();
        chk("rst_flags", {27'd0, bus.busy, bus.ser_en, bus.word_req, bus.done, bus.err}, 32'd0);
        chk("rst_addr", bus.word_addr, 32'd0);
        chk("rst_word", bus.ser_word, 32'd0);
        rst_n = 1'b1;
        tick();
        run_cmd(64'h9000_0000_0000_0000, 0, 32'd0, 50, lat);
        chk("id_lat", lat, 3);
        chk("id_words", n_words - s_words, 1);
        chk("id_en_cycles", n_en - s_en, 4);
        chk("id_done", n_done - s_done, 1);
        chk("id_req", n_req - s_req, 0);
        chk("id_err", n_err - s_err, 0);
        run_cmd(64'hB800_0000_0000_0000, 0, 32'd0, 50, lat);
        chk("id2_words", n_words - s_words, 1);
        chk("id2_done", n_done - s_done, 1);
        mdelay = 2;
        run_cmd(64'hB700_0010_0000_0000, 2, 32'h1000, 4000, lat);
        chk("rd_lat", lat, 5);
        chk("rd_acks", n_acks - s_acks, 128);
        chk("rd_words", n_words - s_words, 128);
        chk("rd_starts", n_starts - s_starts, PF ? 1 : 128);
        chk("rd_err", n_err - s_err, 0);
        chk("rd_done", n_done - s_done, 1);
        chk("rd_end_addr", bus.word_addr, 32'h1200);
        mdelay = 6;
        run_cmd(64'hB700_0020_0300_0000, 2, 32'h2000, 4000, lat);
        chk("slow_lat", lat, 9);
        chk("slow_words", n_words - s_words, 128);
        chk("slow_starts", n_starts - s_starts, 128);
        chk("slow_err", n_err - s_err, PF ? 127 : 0);
        chk("slow_done", n_done - s_done, 1);
        mdelay = 2;
        run_cmd(64'h9F00_0000_0000_0000, 1, 32'd0, 20000, lat);
        chk("fill_lat", lat, 3);
        chk("fill_words", n_words - s_words, 2048);
        chk("fill_done", n_done - s_done, 1);
        chk("fill_req", n_req - s_req, 0);
        snap();
        bus.cmd = 64'h1200_0000_0000_0000;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        chk("bad_decode", {30'd0, bus.busy, bus.err}, 32'd3);
        tick();
        chk("bad_idle", {30'd0, bus.busy, bus.err}, 32'd0);
        tick();
        chk("bad_err", n_err - s_err, 1);
        chk("bad_en", n_en - s_en, 0);
        chk("bad_req", n_req - s_req, 0);
        chk("bad_done", n_done - s_done, 0);
        mem_en = 1'b0;
        snap();
        bus.cmd = 64'hB700_0030_0000_0000;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 10 && !bus.word_req; i++) tick();
        chk("abt_req_up", {31'd0, bus.word_req}, 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abt_idle", {29'd0, bus.busy, bus.word_req, bus.ser_en}, 32'd0);
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        chk("abt_late_ack", {29'd0, bus.busy, bus.word_req, bus.ser_en}, 32'd0);
        tick();
        chk("abt_quiet", {29'd0, bus.busy, bus.word_req, bus.ser_en}, 32'd0);
        bus.cmd = 64'h9000_0000_0000_0000;
        bus.cmd_valid = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        bus.abort = 1'b0;
        chk("abt_cmd_drop", {31'd0, bus.busy}, 32'd0);
        tick();
        chk("abt_cmd_drop2", {31'd0, bus.busy}, 32'd0);
        chk("abt_no_words", n_words - s_words, 0);
        mem_en = 1'b1;
        run_cmd(64'h9000_0000_0000_0000, 0, 32'd0, 50, lat);
        chk("post_id_words", n_words - s_words, 1);
        chk("post_id_done", n_done - s_done, 1);
        run_cmd(64'hB700_0030_0000_0000, 2, 32'h3000, 4000, lat);
        chk("post_rd_words", n_words - s_words, 128);
        chk("post_rd_done", n_done - s_done, 1);
        chk("post_rd_err", n_err - s_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
